seq_mult_cla: RTL and testbench

SEQ_MULT_CLA -- requirements
Module: seq_mult_cla

---
 rtl/seq_mult_cla.sv | 121 ++++++++++++
 tb/tb_seq_mult_cla.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_cla.sv
// Sequential shift-and-add unsigned multiplier with a three-state handshake FSM.
// Each iteration adds through chained 4-bit carry look-ahead slices.
`timescale 1ns/1ps
module seq_mult_cla #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               product_valid,
  input  logic               product_ready,
  output logic [2*WIDTH-1:0] Product
);

  localparam int unsigned CntW   = $clog2(WIDTH + 1);
  localparam int unsigned Slices = WIDTH / 4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   upper_q, upper_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               sum_carry;
  logic [3:0]         slice_a, slice_b, slice_g, slice_p;
  logic [4:0]         slice_c;

  // A zero addend leaves upper unchanged with no carry when the multiplier LSB is 0.
  assign addend = mplier_q[0] ? mcand_q : '0;

  always_comb begin
    sum       = '0;
    sum_carry = 1'b0;
    slice_a   = '0;
    slice_b   = '0;
    slice_g   = '0;
    slice_p   = '0;
    slice_c   = '0;
    for (int s = 0; s < Slices; s++) begin
      slice_a    = upper_q[4*s +: 4];
      slice_b    = addend[4*s +: 4];
      slice_g    = slice_a & slice_b;
      slice_p    = slice_a ^ slice_b;
      slice_c[0] = sum_carry;
      slice_c[1] = slice_g[0] | (slice_p[0] & slice_c[0]);
      slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0])
                 | (slice_p[1] & slice_p[0] & slice_c[0]);
      slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1])
                 | (slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
      slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2])
                 | (slice_p[3] & slice_p[2] & slice_g[1])
                 | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
      sum[4*s +: 4] = slice_p ^ slice_c[3:0];
      sum_carry     = slice_c[4];
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    upper_d  = upper_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          mcand_d  = A;
          mplier_d = B;
          upper_d  = '0;
          cnt_d    = '0;
        end
      end
      StRun: begin
        // {carry, sum, multiplier} shifted right by one
        upper_d  = {sum_carry, sum[WIDTH-1:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (product_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      upper_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      upper_q  <= upper_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready         = (state_q == StIdle);
  assign product_valid = (state_q == StDone);
  assign Product       = {upper_q, mplier_q};

endmodule

// File: tb/tb_seq_mult_cla.sv
// Directed bench for seq_mult_cla at WIDTH=4 and WIDTH=8 with hand-computed products.
`timescale 1ns/1ps
module tb_seq_mult_cla;

  logic        clk;
  logic        rst_n;
  logic        start4, ready4, valid4, pready4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;
  logic        start8, ready8, valid8, pready8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  int          checks;
  int          errors;

  seq_mult_cla #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .ready(ready4),
    .product_valid(valid4), .product_ready(pready4), .Product(prod4)
  );

  seq_mult_cla #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .ready(ready8),
    .product_valid(valid8), .product_ready(pready8), .Product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start4 = 1'b1; start8 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    tick(); tick();
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready4); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid4); end
    checks++; if (prod4 !== 8'h00) begin errors++; $display("FAIL reset_product: got %h expected 00", prod4); end
    checks++; if (prod8 !== 16'h0) begin errors++; $display("FAIL reset_product8: got %h expected 0000", prod8); end
    rst_n = 1'b1;
    #1;
    start4 = 1'b0; start8 = 1'b0;
    tick();
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL release_no_start: ready got %b expected 1", ready4); end
  endtask

  task automatic test_max();
    pready4 = 1'b1; a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    tick();
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    for (int c = 1; c <= 5; c++) begin
      checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL max_ready_c%0d: got %b expected 0", c, ready4); end
      if (c < 5) begin
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL max_valid_c%0d: got %b expected 0", c, valid4); end
        tick();
      end else begin
        checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL max_valid_c5: got %b expected 1", valid4); end
        checks++; if (prod4 !== 8'hE1) begin errors++; $display("FAIL max_product: got %h expected e1", prod4); end
      end
    end
    tick();
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL max_ready_c6: got %b expected 1", ready4); end
    checks++; if (prod4 !== 8'hE1) begin errors++; $display("FAIL max_hold_idle: got %h expected e1", prod4); end
  endtask

  task automatic test_zero();
    pready4 = 1'b1; a4 = 4'd0; b4 = 4'd9; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick(); tick();
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL zero_valid_c4: got %b expected 0", valid4); end
    tick();
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL zero_valid_c5: got %b expected 1", valid4); end
    checks++; if (prod4 !== 8'h00) begin errors++; $display("FAIL zero_product: got %h expected 00", prod4); end
    tick();
    a4 = 4'd9; b4 = 4'd7; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL nine_seven_valid: got %b expected 1", valid4); end
    checks++; if (prod4 !== 8'h3F) begin errors++; $display("FAIL nine_seven_product: got %h expected 3f", prod4); end
    tick();
  endtask

  task automatic test_stall();
    pready4 = 1'b0; a4 = 4'd12; b4 = 4'd11; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %b expected 1", k, valid4); end
      checks++; if (prod4 !== 8'h84) begin errors++; $display("FAIL stall_product_%0d: got %h expected 84", k, prod4); end
      tick();
    end
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL stall_valid_c8: got %b expected 1", valid4); end
    pready4 = 1'b1;
    tick();
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL stall_exit_ready: got %b expected 1", ready4); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL stall_exit_valid: got %b expected 0", valid4); end
    checks++; if (prod4 !== 8'h84) begin errors++; $display("FAIL stall_exit_product: got %h expected 84", prod4); end
  endtask

  task automatic test_ignored_start();
    pready4 = 1'b1; a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    tick();
    start4 = 1'b0;
    checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL ign_run_ready: got %b expected 0", ready4); end
    tick(); tick();
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL ign_valid: got %b expected 1", valid4); end
    checks++; if (prod4 !== 8'h0F) begin errors++; $display("FAIL ign_product: got %h expected 0f", prod4); end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL ign_done_start: ready got %b expected 1", ready4); end
    checks++; if (prod4 !== 8'h0F) begin errors++; $display("FAIL ign_no_recapture: got %h expected 0f", prod4); end
    tick();
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL ign_idle_ready: got %b expected 1", ready4); end
  endtask

  task automatic test_reset_abort();
    pready4 = 1'b1; a4 = 4'd13; b4 = 4'd14; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready4); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", valid4); end
    checks++; if (prod4 !== 8'h00) begin errors++; $display("FAIL abort_product: got %h expected 00", prod4); end
    tick();
    rst_n = 1'b1;
    a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++; if (ready4 !== 1'b0) begin errors++; $display("FAIL abort_restart: ready got %b expected 0", ready4); end
    tick(); tick(); tick();
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL abort_valid_c4: got %b expected 0", valid4); end
    tick();
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL abort_valid_c5: got %b expected 1", valid4); end
    checks++; if (prod4 !== 8'h06) begin errors++; $display("FAIL abort_product_c5: got %h expected 06", prod4); end
    tick();
  endtask

  task automatic test_width8();
    logic [7:0]  va, vb;
    logic [15:0] exp;
    logic [7:0]  da [4];
    logic [7:0]  db [4];
    da[0] = 8'd255; db[0] = 8'd255;
    da[1] = 8'd0;   db[1] = 8'd255;
    da[2] = 8'd1;   db[2] = 8'd1;
    da[3] = 8'd128; db[3] = 8'd2;
    pready8 = 1'b1;
    for (int n = 0; n < 2004; n++) begin
      if (n < 4) begin
        va = da[n]; vb = db[n];
      end else begin
        va = 8'($urandom_range(0, 255)); vb = 8'($urandom_range(0, 255));
      end
      exp = 16'(va) * 16'(vb);
      a8 = va; b8 = vb; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = ~va; b8 = ~vb;
      for (int c = 1; c < 8; c++) tick();
      checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL w8_early_valid_%0d: got %b expected 0", n, valid8); end
      tick();
      checks++; if (valid8 !== 1'b1) begin errors++; $display("FAIL w8_valid_%0d: got %b expected 1", n, valid8); end
      checks++; if (prod8 !== exp) begin errors++; $display("FAIL w8_product_%0d: %0d*%0d got %h expected %h", n, va, vb, prod8, exp); end
      tick();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0; pready4 = 1'b0; pready8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    test_reset();
    test_max();
    test_zero();
    test_stall();
    test_ignored_start();
    test_reset_abort();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
